wash_phase_sequencer: RTL

Timed phase sequencer for the washing-machine controller. Once the controller grants a paid cycle with a start pulse, this block steps the drum hardware through fill, heat, soak, wash, rinse and spin. It owns the phase-duration counters, the fill and heat timeouts and the lid interlock, and drives the per-phase operation enables. The controller sees only busy/done/fault and can abort with cancel.

---
 rtl/wash_phase_sequencer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/wash_phase_sequencer.sv
// Timed phase sequencer for the washing-machine drum: fill, heat, soak, wash,
// rinse, spin, with fill/heat timeouts, a lid interlock and cancel/fault handling.
module wash_phase_sequencer #(
  parameter int unsigned PRESCALE     = 4,
  parameter int unsigned SOAK_TICKS   = 3,
  parameter int unsigned WASH_TICKS   = 5,
  parameter int unsigned RINSE_TICKS  = 4,
  parameter int unsigned SPIN_TICKS   = 3,
  parameter int unsigned FILL_TIMEOUT = 6,
  parameter int unsigned HEAT_TIMEOUT = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       lid,
  input  logic       cancel,
  input  logic       water_full,
  input  logic       water_hot,
  output logic       busy,
  output logic       water_Intake,
  output logic       heater_On,
  output logic       soak_Operation,
  output logic       wash_Operation,
  output logic       rinse_Operation,
  output logic       spin_Operation,
  output logic [2:0] phase,
  output logic       done,
  output logic       fault
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    HEAT  = 3'd2,
    SOAK  = 3'd3,
    WASH  = 3'd4,
    RINSE = 3'd5,
    SPIN  = 3'd6,
    FAULT = 3'd7
  } state_e;

  localparam logic [7:0] PRESC_LAST  = 8'(PRESCALE - 1);
  localparam logic [7:0] SOAK_LEN    = 8'(SOAK_TICKS);
  localparam logic [7:0] WASH_LEN    = 8'(WASH_TICKS);
  localparam logic [7:0] RINSE_LEN   = 8'(RINSE_TICKS);
  localparam logic [7:0] SPIN_LEN    = 8'(SPIN_TICKS);
  localparam logic [7:0] FILL_LIMIT  = 8'(FILL_TIMEOUT);
  localparam logic [7:0] HEAT_LIMIT  = 8'(HEAT_TIMEOUT);

  state_e     state_q, state_d;
  logic [7:0] presc_q, presc_d;
  logic [7:0] ticks_q, ticks_d;
  logic       done_q, done_d;

  logic       tick_s;
  logic       freeze_s;
  logic       counting_s;
  logic [7:0] ticks_inc_s;

  // Tick strobe, saturating tick increment and lid-freeze qualifier.
  always_comb begin
    tick_s      = (presc_q == PRESC_LAST);
    ticks_inc_s = (ticks_q == 8'd255) ? ticks_q : (ticks_q + 8'd1);
    freeze_s    = lid && (state_q inside {SOAK, WASH, RINSE, SPIN});
    counting_s  = !(state_q inside {IDLE, FAULT});
  end

  // Next state, counters and done pulse; cancel outranks the lid freeze,
  // and a sensor outranks a timeout landing on the same tick.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    ticks_d = ticks_q;
    done_d  = 1'b0;
    if (cancel && (state_q != IDLE)) begin
      state_d = IDLE;
    end else if (freeze_s) begin
      state_d = state_q;
    end else begin
      if (counting_s) begin
        presc_d = tick_s ? 8'd0 : (presc_q + 8'd1);
        ticks_d = tick_s ? ticks_inc_s : ticks_q;
      end else begin
        presc_d = 8'd0;
        ticks_d = 8'd0;
      end
      case (state_q)
        IDLE: begin
          if (start && !lid && !cancel) state_d = FILL;
          else                          state_d = IDLE;
        end
        FILL: begin
          if (water_full)                                 state_d = HEAT;
          else if (tick_s && (ticks_inc_s == FILL_LIMIT)) state_d = FAULT;
          else                                            state_d = FILL;
        end
        HEAT: begin
          if (water_hot)                                  state_d = SOAK;
          else if (tick_s && (ticks_inc_s == HEAT_LIMIT)) state_d = FAULT;
          else                                            state_d = HEAT;
        end
        SOAK: begin
          if (tick_s && (ticks_inc_s == SOAK_LEN)) state_d = WASH;
          else                                     state_d = SOAK;
        end
        WASH: begin
          if (tick_s && (ticks_inc_s == WASH_LEN)) state_d = RINSE;
          else                                     state_d = WASH;
        end
        RINSE: begin
          if (tick_s && (ticks_inc_s == RINSE_LEN)) state_d = SPIN;
          else                                      state_d = RINSE;
        end
        SPIN: begin
          if (tick_s && (ticks_inc_s == SPIN_LEN)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = SPIN;
          end
        end
        FAULT: state_d = FAULT;
        default: state_d = IDLE;
      endcase
    end
    if (state_d != state_q) begin
      presc_d = 8'd0;
      ticks_d = 8'd0;
    end
  end

  // State, counters and done pulse; reset clears everything immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      presc_q <= 8'd0;
      ticks_q <= 8'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      ticks_q <= ticks_d;
      done_q  <= done_d;
    end
  end

  // Moore decode of the registered state; an open lid gates the phase enables at once.
  always_comb begin
    phase           = state_q;
    busy            = counting_s;
    water_Intake    = (state_q == FILL);
    heater_On       = (state_q == HEAT);
    soak_Operation  = (state_q == SOAK)  && !lid;
    wash_Operation  = (state_q == WASH)  && !lid;
    rinse_Operation = (state_q == RINSE) && !lid;
    spin_Operation  = (state_q == SPIN)  && !lid;
    fault           = (state_q == FAULT);
    done            = done_q;
  end

endmodule
